// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer arbiter: grant states and starvation limit.
package fb_pkg;

  // Which RAM operation the arbiter drives in the following cycle.
  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_READ  = 2'd1,
    G_WRITE = 2'd2
  } grant_e;

  // Number of consecutive full-and-blocked cycles that flags starvation.
  localparam int STARVE_LIMIT = 256;
  localparam int STARVE_CNT_W = $clog2(STARVE_LIMIT);

endpackage : fb_pkg

// File: rtl/fb_wr_fifo.sv
// Write-offer FIFO between the PPU and the framebuffer arbiter.
// No bypass paths: a push into an empty FIFO is not visible at the pop
// side until the next cycle, and a full FIFO refuses pushes even while popping.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] pop_addr,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign full      = (r_level == LVL_W'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign pop_addr  = r_addr_mem[r_rd_ptr];
  assign pop_data  = r_data_mem[r_rd_ptr];

  // Storage write on accepted push.
  // NOTE: the storage array has no reset; occupancy is tracked by r_level, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_addr_mem[r_wr_ptr] <= push_addr;
      r_data_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule : fb_wr_fifo

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: scanout reads have strict priority,
// PPU writes are buffered in a FIFO and drained on cycles without a read.
// All RAM-side outputs are registered; read data returns two cycles after rd_req.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              starve
);

  grant_e                  r_state;
  logic                    r_mem_en;
  logic                    r_mem_we;
  logic [ADDR_W-1:0]       r_mem_addr;
  logic [DATA_W-1:0]       r_mem_wdata;
  logic                    r_rd_valid;
  logic [DATA_W-1:0]       r_rd_data;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic                    r_starve;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_starve_cond;
  logic [ADDR_W-1:0]       w_pop_addr;
  logic [DATA_W-1:0]       w_pop_data;

  // A write drains only on cycles without a scanout request.
  assign w_pop         = !rd_req && !w_empty;
  assign w_starve_cond = w_full && rd_req;
  assign wr_ready      = !w_full;

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign starve    = r_starve;

  fb_wr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_valid),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (w_pop),
    .pop_addr  (w_pop_addr),
    .pop_data  (w_pop_data),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level)
  );

  // Grant FSM: decide this cycle, drive the registered RAM port next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= G_IDLE;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (rd_req) begin
      r_state    <= G_READ;
      r_mem_en   <= 1'b1;
      r_mem_we   <= 1'b0;
      r_mem_addr <= rd_addr;
    end else if (!w_empty) begin
      r_state     <= G_WRITE;
      r_mem_en    <= 1'b1;
      r_mem_we    <= 1'b1;
      r_mem_addr  <= w_pop_addr;
      r_mem_wdata <= w_pop_data;
    end else begin
      r_state  <= G_IDLE;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
    end
  end

  // Capture RAM read data in the cycle the read is on the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= (r_state == G_READ);
      if (r_state == G_READ) r_rd_data <= mem_rdata;
    end
  end

  // Starvation watchdog: consecutive full-and-blocked cycles; flag is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_starve     <= 1'b0;
    end else if (w_pop || !w_starve_cond) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt == STARVE_CNT_W'(STARVE_LIMIT - 1)) begin
      r_starve <= 1'b1;
    end else begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule : fb_arbiter

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed steps plus a random phase,
// with a FIFO/starve model in the driver and a RAM-port scoreboard in a monitor.
module tb_fb_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 2;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [LW-1:0] fifo_level;
  logic          starve;

  fb_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .fifo_level (fifo_level),
    .starve     (starve)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM: combinational read, write on clock edge.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;

  typedef struct {
    int unsigned   due;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  ev_t  issue_q[$];
  ev_t  rdq[$];
  wr_t  m_fifo[$];
  int   m_cnt = 0;
  bit   m_starve = 1'b0;
  bit   mon_en = 1'b0;
  logic [DW-1:0] last_wr [0:(1<<AW)-1];
  bit   written [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, check FIFO-side outputs, advance the model.
  task automatic drive(input bit rd, input logic [AW-1:0] ra, input bit wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int  sz;
    bit  acc;
    wr_t e;
    rd_req   = rd;
    rd_addr  = ra;
    wr_valid = wv;
    wr_addr  = wa;
    wr_data  = wd;
    sz = m_fifo.size();
    check("fifo_level", 32'(fifo_level), 32'(sz));
    check("wr_ready", 32'(wr_ready), 32'(sz < DEPTH));
    check("starve", 32'(starve), 32'(m_starve));
    acc = wv && (sz < DEPTH);
    if (rd) begin
      issue_q.push_back('{due: cyc + 1, we: 1'b0, addr: ra, data: '0});
    end else if (sz > 0) begin
      e = m_fifo.pop_front();
      issue_q.push_back('{due: cyc + 1, we: 1'b1, addr: e.addr, data: e.data});
    end
    if (acc) begin
      m_fifo.push_back('{addr: wa, data: wd});
      last_wr[wa] = wd;
      written[wa] = 1'b1;
    end
    if (sz == DEPTH && rd) begin
      if (m_cnt == 255) m_starve = 1'b1;
      else m_cnt++;
    end else begin
      m_cnt = 0;
    end
  endtask

  task automatic step(input bit rd, input logic [AW-1:0] ra, input bit wv,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    @(posedge clk);
    #1;
    drive(rd, ra, wv, wa, wd);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0);
  endtask

  // RAM-port and read-return scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (issue_q.size() > 0 && issue_q[0].due == cyc) begin
        e = issue_q.pop_front();
        check("mem_en", 32'(mem_en), 32'd1);
        check("mem_we", 32'(mem_we), 32'(e.we));
        check("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.we) check("mem_wdata", 32'(mem_wdata), 32'(e.data));
        else rdq.push_back('{due: cyc + 1, we: 1'b0, addr: e.addr, data: ram[e.addr]});
      end else begin
        check("mem_idle", {30'd0, mem_en, mem_we}, 32'd0);
      end
      if (rdq.size() > 0 && rdq[0].due == cyc) begin
        e = rdq.pop_front();
        check("rd_valid", 32'(rd_valid), 32'd1);
        check("rd_data", 32'(rd_data), 32'(e.data));
      end else begin
        check("rd_valid_idle", 32'(rd_valid), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and reset-state checks.
    repeat (3) @(posedge clk);
    #1;
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_starve", 32'(starve), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Preload pixel 5 with 2'b10 through the write path, then read it in cycle 10.
    step(1'b0, '0, 1'b1, AW'(5), 2'b10);
    while (cyc < 9) idle();
    step(1'b1, AW'(5), 1'b0, '0, '0);
    idle();
    check("rd_issue_en", 32'(mem_en), 32'd1);
    check("rd_issue_we", 32'(mem_we), 32'd0);
    check("rd_issue_addr", 32'(mem_addr), 32'h5);
    idle();
    check("rd_ret_valid", 32'(rd_valid), 32'd1);
    check("rd_ret_data", 32'(rd_data), 32'h2);
    repeat (3) idle();

    // Fill the FIFO under continuous scanout; writes must wait.
    for (int i = 0; i < 4; i++)
      step(1'b1, AW'(i), 1'b1, AW'(32'h10 + i), DW'(i + 1));
    step(1'b1, '0, 1'b0, '0, '0);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_wr_ready", 32'(wr_ready), 32'd0);

    // Hold full with rd_req=1: starve rises after 256 consecutive cycles.
    for (int k = 2; k <= 256; k++) step(1'b1, AW'(k), 1'b0, '0, '0);
    check("starve_before", 32'(starve), 32'd0);
    step(1'b1, '0, 1'b0, '0, '0);
    check("starve_set", 32'(starve), 32'd1);

    // Pop and offered push in the same full cycle: push refused.
    step(1'b0, '0, 1'b1, AW'(32'h20), 2'b11);
    check("nobypass_ready", 32'(wr_ready), 32'd0);
    idle();
    check("nobypass_level", 32'(fifo_level), 32'd3);
    repeat (5) idle();
    check("drained_level", 32'(fifo_level), 32'd0);
    check("starve_sticky", 32'(starve), 32'd1);

    // Reset mid-operation: read in flight, two entries buffered.
    step(1'b1, AW'(1), 1'b1, AW'(32'h30), 2'b01);
    step(1'b1, AW'(2), 1'b1, AW'(32'h31), 2'b10);
    step(1'b1, AW'(3), 1'b0, '0, '0);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    rd_req = 1'b0;
    wr_valid = 1'b0;
    issue_q.delete();
    rdq.delete();
    m_fifo.delete();
    m_cnt = 0;
    m_starve = 1'b0;
    #1;
    check("mrst_mem_en", 32'(mem_en), 32'd0);
    check("mrst_mem_we", 32'(mem_we), 32'd0);
    check("mrst_mem_addr", 32'(mem_addr), 32'd0);
    check("mrst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("mrst_rd_valid", 32'(rd_valid), 32'd0);
    check("mrst_rd_data", 32'(rd_data), 32'd0);
    check("mrst_level", 32'(fifo_level), 32'd0);
    check("mrst_wr_ready", 32'(wr_ready), 32'd1);
    check("mrst_starve", 32'(starve), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle();
      check("post_rst_we", 32'(mem_we), 32'd0);
      check("post_rst_valid", 32'(rd_valid), 32'd0);
    end

    // Random traffic against the RAM model.
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 99) < 40, AW'(32'h40 + $urandom_range(0, 31)),
           $urandom_range(0, 99) < 60, AW'(32'h40 + $urandom_range(0, 31)),
           DW'($urandom_range(0, 3)));
    for (int i = 0; i < DEPTH + 3; i++) idle();
    for (int a = 32'h40; a < 32'h60; a++)
      if (written[a]) check($sformatf("ram[%0h]", a), 32'(ram[a]), 32'(last_wr[a]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fb_arbiter
